// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//
// Purpose:
//   Phase sequencer for a two-road intersection (main road / side road) with
//   an optional pedestrian walk phase. Drives one external Timer: every phase
//   entry loads the phase duration through timer_value and pulses start_timer
//   for one cycle. The sequencer advances when the Timer reports expired.
//
// Optional feature:
//   PED_WALK_EN - when defined, walk_req, the sticky walk request and the WALK
//                 phase are active. When undefined, walk_req is ignored,
//                 ALLRED_A always proceeds to SIDE_G, and walk_light stays 0.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous, active-high reset
//   side_car     in   side-road vehicle sensor (level)
//   walk_req     in   pedestrian button (level or pulse)
//   expired      in   Timer expired flag
//   timer_value  out  [4:0] duration loaded into the Timer
//   start_timer  out  one-cycle load strobe to the Timer
//   main_light   out  [2:0] {red,yellow,green}, one-hot
//   side_light   out  [2:0] {red,yellow,green}, one-hot
//   walk_light   out  pedestrian walk lamp
//   phase        out  [2:0] current phase encoding (debug)
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module traffic_light_ctrl #(
  parameter int unsigned T_GREEN  = 32'd10,
  parameter int unsigned T_YELLOW = 32'd3,
  parameter int unsigned T_ALLRED = 32'd1,
  parameter int unsigned T_SIDE   = 32'd6,
  parameter int unsigned T_EXT    = 32'd3,
  parameter int unsigned T_WALK   = 32'd5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       side_car,
  input  logic       walk_req,
  input  logic       expired,
  output logic [4:0] timer_value,
  output logic       start_timer,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_light,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_G   = 3'd0,
    MAIN_Y   = 3'd1,
    ALLRED_A = 3'd2,
    SIDE_G   = 3'd3,
    SIDE_Y   = 3'd4,
    ALLRED_B = 3'd5,
    WALK     = 3'd6
  } phase_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // A zero duration would never let the Timer expire meaningfully, so it is
  // forced to 1; anything beyond the 5-bit Timer range saturates.
  function automatic logic [4:0] clamp_dur(input int unsigned dur);
    logic [4:0] res;
    if (dur == 32'd0) begin
      res = 5'd1;
    end else if (dur > 32'd31) begin
      res = 5'd31;
    end else begin
      res = dur[4:0];
    end
    return res;
  endfunction

  localparam logic [4:0] DUR_GREEN  = clamp_dur(T_GREEN);
  localparam logic [4:0] DUR_YELLOW = clamp_dur(T_YELLOW);
  localparam logic [4:0] DUR_ALLRED = clamp_dur(T_ALLRED);
  localparam logic [4:0] DUR_SIDE   = clamp_dur(T_SIDE);
  localparam logic [4:0] DUR_EXT    = clamp_dur(T_EXT);
  localparam logic [4:0] DUR_WALK   = clamp_dur(T_WALK);

  // Duration to load on entry into a given phase.
  function automatic logic [4:0] phase_dur(input phase_e ph);
    logic [4:0] res;
    case (ph)
      MAIN_G:   res = DUR_GREEN;
      MAIN_Y:   res = DUR_YELLOW;
      ALLRED_A: res = DUR_ALLRED;
      SIDE_G:   res = DUR_SIDE;
      SIDE_Y:   res = DUR_YELLOW;
      ALLRED_B: res = DUR_ALLRED;
      WALK:     res = DUR_WALK;
      default:  res = DUR_GREEN;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State and output flops
  // ---------------------------------------------------------------------------
  phase_e     phase_q,       phase_d;
  logic       start_timer_q, start_timer_d;
  logic [4:0] timer_value_q, timer_value_d;
  logic [2:0] main_light_q,  main_light_d;
  logic [2:0] side_light_q,  side_light_d;
  logic       walk_light_q,  walk_light_d;
  logic       walk_pend_q,   walk_pend_d;
  logic       ext_used_q,    ext_used_d;
  logic       armed_q,       armed_d;
  logic       arm_dly_q,     arm_dly_d;
  logic       load_pend_q,   load_pend_d;

  // Combinational helpers
  logic       fire_s;       // armed and Timer reports expiry
  logic       walk_pend_s;  // walk request including this cycle's walk_req
  logic       ext_s;        // side-green extension reload this cycle
  logic       entry_s;      // phase changes at the next edge

`ifdef PED_WALK_EN
  // A request is latched on any cycle outside WALK and counts immediately,
  // so a walk_req coinciding with an expiry still steers that transition.
  always_comb begin
    if (walk_req && (phase_q != WALK)) begin
      walk_pend_s = 1'b1;
    end else begin
      walk_pend_s = walk_pend_q;
    end
  end
`else
  logic walk_req_unused_s;
  assign walk_req_unused_s = walk_req;

  // Without the pedestrian feature the request path is permanently idle.
  always_comb begin
    walk_pend_s = walk_pend_q;
  end
`endif

  // State register: synchronous reset returns to main green and schedules a
  // Timer load on the first cycle after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q       <= MAIN_G;
      start_timer_q <= 1'b0;
      timer_value_q <= DUR_GREEN;
      main_light_q  <= LAMP_GRN;
      side_light_q  <= LAMP_RED;
      walk_light_q  <= 1'b0;
      walk_pend_q   <= 1'b0;
      ext_used_q    <= 1'b0;
      armed_q       <= 1'b0;
      arm_dly_q     <= 1'b0;
      load_pend_q   <= 1'b1;
    end else begin
      phase_q       <= phase_d;
      start_timer_q <= start_timer_d;
      timer_value_q <= timer_value_d;
      main_light_q  <= main_light_d;
      side_light_q  <= side_light_d;
      walk_light_q  <= walk_light_d;
      walk_pend_q   <= walk_pend_d;
      ext_used_q    <= ext_used_d;
      armed_q       <= armed_d;
      arm_dly_q     <= arm_dly_d;
      load_pend_q   <= load_pend_d;
    end
  end

  // Next-state logic: phase transitions, extension bookkeeping, Timer load.
  always_comb begin
    phase_d     = phase_q;
    ext_used_d  = ext_used_q;
    walk_pend_d = walk_pend_s;
    ext_s       = 1'b0;
    fire_s      = armed_q & expired;

    case (phase_q)
      MAIN_G: begin
        // No reload while holding: green simply waits for a demand.
        if (fire_s && (side_car || walk_pend_s)) begin
          phase_d = MAIN_Y;
        end else begin
          phase_d = MAIN_G;
        end
      end
      MAIN_Y: begin
        if (fire_s) begin
          phase_d = ALLRED_A;
        end else begin
          phase_d = MAIN_Y;
        end
      end
      ALLRED_A: begin
        if (fire_s) begin
`ifdef PED_WALK_EN
          if (walk_pend_s) begin
            phase_d = WALK;
          end else begin
            phase_d = SIDE_G;
          end
`else
          phase_d = SIDE_G;
`endif
        end else begin
          phase_d = ALLRED_A;
        end
      end
      SIDE_G: begin
        if (fire_s) begin
          if (side_car && !ext_used_q) begin
            // One extension per side-green visit; stays in SIDE_G.
            ext_used_d = 1'b1;
            ext_s      = 1'b1;
            phase_d    = SIDE_G;
          end else begin
            phase_d = SIDE_Y;
          end
        end else begin
          phase_d = SIDE_G;
        end
      end
      SIDE_Y: begin
        if (fire_s) begin
          phase_d = ALLRED_B;
        end else begin
          phase_d = SIDE_Y;
        end
      end
      ALLRED_B: begin
        if (fire_s) begin
          phase_d    = MAIN_G;
          ext_used_d = 1'b0;
        end else begin
          phase_d = ALLRED_B;
        end
      end
      WALK: begin
`ifdef PED_WALK_EN
        if (fire_s) begin
          phase_d     = SIDE_G;
          walk_pend_d = 1'b0;
        end else begin
          phase_d = WALK;
        end
`else
        // Unreachable in this build; recover to main green.
        phase_d = MAIN_G;
`endif
      end
      default: begin
        // Illegal encoding: recover to main green with a fresh load.
        phase_d    = MAIN_G;
        ext_used_d = 1'b0;
      end
    endcase

    entry_s = (phase_d != phase_q);

    // Timer load: every entry, every extension, and the post-reset cycle.
    start_timer_d = entry_s | ext_s | load_pend_q;
    if (entry_s) begin
      timer_value_d = phase_dur(phase_d);
    end else if (ext_s) begin
      timer_value_d = DUR_EXT;
    end else if (load_pend_q) begin
      timer_value_d = DUR_GREEN;
    end else begin
      timer_value_d = timer_value_q;
    end
    load_pend_d = 1'b0;

    // The Timer clears expired one cycle after it sees the strobe, so the
    // flag is trusted only from the second cycle after the strobe onward.
    if (start_timer_d) begin
      arm_dly_d = 1'b0;
      armed_d   = 1'b0;
    end else begin
      arm_dly_d = 1'b1;
      armed_d   = arm_dly_q;
    end
  end

  // Output logic: lamps follow the phase being entered so they switch
  // together with the phase flop.
  always_comb begin
    main_light_d = LAMP_RED;
    side_light_d = LAMP_RED;
    walk_light_d = 1'b0;
    case (phase_d)
      MAIN_G:   main_light_d = LAMP_GRN;
      MAIN_Y:   main_light_d = LAMP_YEL;
      ALLRED_A: main_light_d = LAMP_RED;
      SIDE_G:   side_light_d = LAMP_GRN;
      SIDE_Y:   side_light_d = LAMP_YEL;
      ALLRED_B: side_light_d = LAMP_RED;
      WALK: begin
`ifdef PED_WALK_EN
        walk_light_d = 1'b1;
`else
        walk_light_d = 1'b0;
`endif
      end
      default: begin
        main_light_d = LAMP_RED;
        side_light_d = LAMP_RED;
      end
    endcase
  end

  assign phase       = phase_q;
  assign start_timer = start_timer_q;
  assign timer_value = timer_value_q;
  assign main_light  = main_light_q;
  assign side_light  = side_light_q;
  assign walk_light  = walk_light_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl
//
// Directed bench for traffic_light_ctrl with default parameters. The Timer is
// represented by driving expired directly. Outputs are sampled 1 time unit
// after each rising edge; inputs change at the same point.
// -----------------------------------------------------------------------------
module tb_traffic_light_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       side_car;
  logic       walk_req;
  logic       expired;
  logic [4:0] timer_value;
  logic       start_timer;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk_light;
  logic [2:0] phase;

  int n_total = 0;
  int n_bad   = 0;
  logic [2:0] cur_ph;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  always #5 clock = ~clock;

  traffic_light_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .side_car    (side_car),
    .walk_req    (walk_req),
    .expired     (expired),
    .timer_value (timer_value),
    .start_timer (start_timer),
    .main_light  (main_light),
    .side_light  (side_light),
    .walk_light  (walk_light),
    .phase       (phase)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] ph, input logic st,
                         input logic [4:0] tv, input logic [2:0] ml,
                         input logic [2:0] sl, input logic wl);
    chk({tag, ".phase"}, {5'd0, phase},       {5'd0, ph});
    chk({tag, ".start"}, {7'd0, start_timer}, {7'd0, st});
    chk({tag, ".value"}, {3'd0, timer_value}, {3'd0, tv});
    chk({tag, ".main"},  {5'd0, main_light},  {5'd0, ml});
    chk({tag, ".side"},  {5'd0, side_light},  {5'd0, sl});
    chk({tag, ".walk"},  {7'd0, walk_light},  {7'd0, wl});
  endtask

  // With expired held high, a freshly entered phase ignores the flag for two
  // cycles and transitions on the third.
  task automatic advance(input string tag, input logic [2:0] ph, input logic [4:0] tv,
                         input logic [2:0] ml, input logic [2:0] sl, input logic wl);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk({tag, ".hold_phase"}, {5'd0, phase},       {5'd0, cur_ph});
      chk({tag, ".hold_start"}, {7'd0, start_timer}, 8'd0);
    end
    tick;
    chk_out(tag, ph, 1'b1, tv, ml, sl, wl);
    cur_ph = ph;
  endtask

  initial begin
    reset    = 1'b1;
    side_car = 1'b0;
    walk_req = 1'b0;
    expired  = 1'b0;
    tick;
    tick;
    chk_out("reset", 3'd0, 1'b0, 5'd10, G, R, 1'b0);
    chk("reset.ext_used",  {7'd0, dut.ext_used_q},  8'd0);
    chk("reset.walk_pend", {7'd0, dut.walk_pend_q}, 8'd0);

    // First post-reset cycle loads T_GREEN.
    reset = 1'b0;
    tick;
    chk_out("post_reset_load", 3'd0, 1'b1, 5'd10, G, R, 1'b0);
    cur_ph = 3'd0;

    // Expiry with no demand: green holds, no reload.
    expired = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("hold_green.phase", {5'd0, phase},       8'd0);
      chk("hold_green.start", {7'd0, start_timer}, 8'd0);
    end

    // Side demand: full cycle with one extension.
    side_car = 1'b1;
    tick;
    chk_out("main_yellow", 3'd1, 1'b1, 5'd3, Y, R, 1'b0);
    cur_ph = 3'd1;
    // advance() also checks expired is ignored for the strobe cycle and the next.
    advance("allred_a",    3'd2, 5'd1,  R, R, 1'b0);
    advance("side_green",  3'd3, 5'd6,  R, G, 1'b0);
    advance("side_ext",    3'd3, 5'd3,  R, G, 1'b0);
    chk("side_ext.ext_used", {7'd0, dut.ext_used_q}, 8'd1);
    advance("side_yellow", 3'd4, 5'd3,  R, Y, 1'b0);
    advance("allred_b",    3'd5, 5'd1,  R, R, 1'b0);
    advance("back_main",   3'd0, 5'd10, G, R, 1'b0);
    chk("back_main.ext_used", {7'd0, dut.ext_used_q}, 8'd0);

    // Second lap up to SIDE_Y, then reset mid-phase.
    advance("lap2_my",  3'd1, 5'd3, Y, R, 1'b0);
    advance("lap2_ara", 3'd2, 5'd1, R, R, 1'b0);
    advance("lap2_sg",  3'd3, 5'd6, R, G, 1'b0);
    advance("lap2_ext", 3'd3, 5'd3, R, G, 1'b0);
    advance("lap2_sy",  3'd4, 5'd3, R, Y, 1'b0);
    tick;
    chk("lap2_sy.mid_phase", {5'd0, phase}, 8'd4);
    reset = 1'b1;
    tick;
    chk_out("mid_reset", 3'd0, 1'b0, 5'd10, G, R, 1'b0);
    chk("mid_reset.ext_used", {7'd0, dut.ext_used_q}, 8'd0);
    reset    = 1'b0;
    side_car = 1'b0;
    expired  = 1'b0;
    tick;
    chk_out("mid_reset_load", 3'd0, 1'b1, 5'd10, G, R, 1'b0);
    cur_ph = 3'd0;

    // Pedestrian pulse during main green once expiry checks are armed.
    tick;
    tick;
    walk_req = 1'b1;
    tick;
    walk_req = 1'b0;
    chk("walk_pulse.phase", {5'd0, phase}, 8'd0);
`ifdef PED_WALK_EN
    chk("walk_pulse.pend", {7'd0, dut.walk_pend_q}, 8'd1);
    expired = 1'b1;
    tick;
    chk_out("walk_my", 3'd1, 1'b1, 5'd3, Y, R, 1'b0);
    cur_ph = 3'd1;
    advance("walk_ara", 3'd2, 5'd1, R, R, 1'b0);
    advance("walk_ph",  3'd6, 5'd5, R, R, 1'b1);
    chk("walk_ph.pend", {7'd0, dut.walk_pend_q}, 8'd1);
    advance("walk_sg",  3'd3, 5'd6, R, G, 1'b0);
    chk("walk_sg.pend", {7'd0, dut.walk_pend_q}, 8'd0);
    advance("walk_sy",  3'd4, 5'd3, R, Y, 1'b0);
`else
    chk("walk_pulse.pend", {7'd0, dut.walk_pend_q}, 8'd0);
    expired = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("walk_off.phase", {5'd0, phase},       8'd0);
      chk("walk_off.start", {7'd0, start_timer}, 8'd0);
      chk("walk_off.lamp",  {7'd0, walk_light},  8'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
